alu_cmd_issuer: RTL and testbench

Upstream command stage for the ALU. Accepts operation requests on a valid/ready interface, buffers them in a small FIFO, and drives the ALU's enable, opcode and operand ports one command at a time. Also watches the ALU interrupt, reports it to the controller, and returns the acknowledge to the ALU as a one-cycle `alu_irq_clr` pulse.

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_cmd_issuer_if.sv | 11 +
 rtl/alu_cmd_fifo.sv | 37 +++
 rtl/alu_cmd_issuer.sv | 69 ++++++
 tb/tb_alu_cmd_issuer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU command issuer.
package alu_pkg;
  localparam int DATA_W = 8;
  typedef enum logic {MODE_A, MODE_B} alu_mode_e;
  typedef struct packed {
    alu_mode_e         mode;
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_cmd_t;
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, IRQ} issuer_state_e;
endpackage

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: valid/ready command bus carrying mode, opcode and operands.
interface alu_cmd_issuer_if #(parameter int DATA_W = alu_pkg::DATA_W);
  logic              valid;
  logic              ready;
  logic              mode;
  logic [1:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  modport master(output valid, mode, op, a, b, input ready);
  modport slave(input valid, mode, op, a, b, output ready);
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry command FIFO; push when full and pop when empty are dropped.
module alu_cmd_fifo import alu_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter type T     = alu_cmd_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(do_push);
      rptr  <= rptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands and issues them one per enable pulse, relaying the ALU interrupt.
// Define ALU_CMD_IRQ_STALL_EN to halt issuing in an IRQ state until the controller acknowledges.
module alu_cmd_issuer import alu_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_cmd_issuer_if.slave        cmd,
  output logic                   alu_enable,
  output logic                   alu_enable_a,
  output logic                   alu_enable_b,
  output logic [1:0]             alu_op_a,
  output logic [1:0]             alu_op_b,
  output logic [DATA_W-1:0]      alu_in_a,
  output logic [DATA_W-1:0]      alu_in_b,
  input  logic                   alu_irq,
  output logic                   alu_irq_clr,
  output logic                   irq_pending,
  input  logic                   irq_ack,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);
`ifdef ALU_CMD_IRQ_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif
  issuer_state_e state;
  alu_cmd_t in_cmd, head;
  logic full, empty, pop, irq_new;
  assign in_cmd    = '{mode: alu_mode_e'(cmd.mode), op: cmd.op, a: cmd.a, b: cmd.b};
  assign cmd.ready = !full;
  assign irq_new   = state == SETTLE && alu_irq;
  assign pop       = !empty && (state == IDLE || (state == SETTLE && !(STALL && alu_irq)));
  assign busy      = !empty || state != IDLE;
  alu_cmd_fifo #(.DEPTH(DEPTH), .T(alu_cmd_t)) fifo (
    .clk(clk), .rst_n(rst_n), .push(cmd.valid), .pop(pop), .din(in_cmd),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  // A fresh interrupt in SETTLE outranks a same-cycle acknowledge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      alu_enable   <= 1'b0;
      alu_enable_a <= 1'b0;
      alu_enable_b <= 1'b0;
      alu_op_a     <= '0;
      alu_op_b     <= '0;
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      alu_irq_clr  <= 1'b0;
      irq_pending  <= 1'b0;
    end else begin
      state       <= pop ? ISSUE : state == ISSUE ? SETTLE : (STALL && irq_new) ? IRQ :
                     (state == IRQ && !irq_ack) ? IRQ : IDLE;
      alu_enable  <= pop;
      alu_irq_clr <= irq_ack && irq_pending && !irq_new;
      irq_pending <= irq_new || (irq_pending && !irq_ack);
      if (pop) begin
        alu_enable_a <= head.mode == MODE_A;
        alu_enable_b <= head.mode == MODE_B;
        alu_op_a     <= head.mode == MODE_A ? head.op : 2'b00;
        alu_op_b     <= head.mode == MODE_B ? head.op : 2'b00;
        alu_in_a     <= head.a;
        alu_in_b     <= head.b;
      end
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed and random stimulus with a queue scoreboard and occupancy/interrupt reference model.
module tb_alu_cmd_issuer;
  import alu_pkg::*;
  localparam int DEPTH = 4;
`ifdef ALU_CMD_IRQ_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif
  typedef struct packed {
    logic       ena;
    logic       enb;
    logic [1:0] opa;
    logic [1:0] opb;
    logic [7:0] a;
    logic [7:0] b;
  } issue_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr, irq_pending, busy;
  logic alu_irq = 1'b0, irq_ack = 1'b0;
  logic [1:0] alu_op_a, alu_op_b;
  logic [7:0] alu_in_a, alu_in_b;
  logic [2:0] count;
  int tests = 0, fails = 0, model_count = 0, en_seen = 0;
  bit pend_acc, exp_en, was_en, exp_pend, exp_clr, new_irq, nxt_en, saw_full;
  issue_t sb[$];
  issue_t last, got;
  alu_cmd_issuer_if #(.DATA_W(8)) cmd();
  alu_cmd_issuer #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .alu_enable(alu_enable),
    .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b), .alu_op_a(alu_op_a),
    .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_irq(alu_irq),
    .alu_irq_clr(alu_irq_clr), .irq_pending(irq_pending), .irq_ack(irq_ack),
    .busy(busy), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic issue_t decode(logic m, logic [1:0] op, logic [7:0] a, logic [7:0] b);
    return '{!m, m, m ? 2'b00 : op, m ? op : 2'b00, a, b};
  endfunction
  // Monitor: occupancy = accepted - issued; a queued command issues on the cycle after IDLE or SETTLE.
  always @(negedge clk) begin
    got = '{alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b};
    if (!rst_n) begin
      sb.delete();
      last = '0;
      model_count = 0;
      {pend_acc, exp_en, was_en, exp_pend, exp_clr} = '0;
      chk("reset_outputs", {alu_enable, got, alu_irq_clr, irq_pending, busy, count}, '0);
      chk("reset_ready", cmd.ready, 1);
    end else begin
      model_count += int'(pend_acc) - int'(exp_en);
      chk("enable", alu_enable, exp_en);
      if (alu_enable) begin
        en_seen++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL issue_without_command: got enable expected none at %0t", $time);
        end else last = sb.pop_front();
      end
      chk("alu_outputs", got, last);
      chk("pair_exclusive", alu_enable_a & alu_enable_b, 0);
      chk("count", count, model_count);
      chk("ready", cmd.ready, model_count < DEPTH);
      chk("irq_pending", irq_pending, exp_pend);
      chk("irq_clr", alu_irq_clr, exp_clr);
      chk("busy", busy, model_count > 0 || exp_en || was_en || (STALL && exp_pend));
      if (model_count == DEPTH && !cmd.ready) saw_full = 1'b1;
      new_irq  = was_en && alu_irq;
      nxt_en   = !exp_en && model_count > 0 && !(STALL && (new_irq || exp_pend));
      exp_clr  = irq_ack && exp_pend && !new_irq;
      exp_pend = new_irq || (exp_pend && !irq_ack);
      was_en   = exp_en;
      exp_en   = nxt_en;
      pend_acc = cmd.valid && model_count < DEPTH;
      if (pend_acc) sb.push_back(decode(cmd.mode, cmd.op, cmd.a, cmd.b));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(logic m, logic [1:0] op, logic [7:0] a, logic [7:0] b);
    bit r;
    int n = 0;
    cmd.valid = 1'b1; cmd.mode = m; cmd.op = op; cmd.a = a; cmd.b = b;
    do begin
      @(negedge clk);
      r = cmd.ready;
      tick();
      n++;
    end while (!r && n < 100);
    if (!r) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 100 cycles");
    end
    cmd.valid = 1'b0;
  endtask
  task automatic send_rand();
    send(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || count != 0) && n < 200);
    if (busy || count != 0) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy=%0d count=%0d expected idle", busy, count);
    end
    tick();
  endtask
  initial begin
    int base;
    cmd.valid = 1'b1; cmd.mode = 1'b0; cmd.op = 2'b10; cmd.a = 8'hF0; cmd.b = 8'h08;
    repeat (3) tick();
    chk("reset_ready_valid_high", cmd.ready, 1);
    chk("reset_count", count, 0);
    rst_n = 1'b1;
    tick();
    cmd.valid = 1'b0;
    chk("first_push_count", count, 1);
    tick();
    chk("first_issue_enable", alu_enable, 1);
    chk("first_issue_group", {alu_enable_a, alu_enable_b, alu_op_a, alu_op_b}, 6'b10_10_00);
    chk("first_issue_operands", {alu_in_a, alu_in_b}, 16'hF008);
    wait_idle();
    saw_full = 1'b0;
    for (int i = 0; i < 10; i++) send_rand();
    chk("ready_fell_at_full", saw_full, 1);
    wait_idle();
    send(1'b1, 2'b11, 8'hF0, 8'h0F);
    send_rand();
    chk("irq_cmd_issue", {alu_enable, alu_enable_b, alu_op_b}, 4'b1111);
    tick();
    alu_irq = 1'b1;
    tick();
    alu_irq = 1'b0;
    chk("irq_pending_set", irq_pending, 1);
    chk("second_issue", alu_enable, !STALL);
    repeat (3) tick();
    chk("pending_sticky", irq_pending, 1);
    chk("queue_depth", count, STALL ? 1 : 0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("clr_pulse", alu_irq_clr, 1);
    chk("pending_cleared", irq_pending, 0);
    tick();
    chk("clr_one_cycle", alu_irq_clr, 0);
    chk("second_after_ack", alu_enable, STALL);
    wait_idle();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("spurious_ack_no_clr", alu_irq_clr, 0);
    for (int i = 0; i < 400; i++) begin
      cmd.valid = 1'($urandom); cmd.mode = 1'($urandom); cmd.op = 2'($urandom);
      cmd.a = 8'($urandom); cmd.b = 8'($urandom);
      alu_irq = $urandom_range(0, 3) == 0;
      irq_ack = $urandom_range(0, 5) == 0;
      tick();
    end
    cmd.valid = 1'b0; alu_irq = 1'b0; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    wait_idle();
    for (int i = 0; i < 6; i++) send_rand();
    chk("pre_reset_enable", alu_enable, 1);
    chk("pre_reset_count", count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_enable", alu_enable, 0);
    chk("async_reset_count", count, 0);
    chk("async_reset_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    base = en_seen;
    repeat (8) tick();
    chk("no_issue_after_reset", en_seen - base, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
